sd_sector_scheduler: RTL and testbench

//  Sequences the SPI SD-card sector writer. Buffers a 16-bit sample stream in a ping-pong RAM (2 x 256 words),

---
 rtl/sd_sched_pkg.sv | 18 +
 rtl/sd_pingpong_ram.sv | 36 +++
 rtl/sd_sector_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_sd_sector_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_sched_pkg.sv
// Shared types and constants for the SD sector scheduler slice.
package sd_sched_pkg;

  localparam int SECTOR_WORDS = 256;
  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 16;
  localparam int IDX_W        = 8;

  typedef enum logic [2:0] {
    WAIT_INIT,
    IDLE,
    ISSUE,
    WAIT_BUSY,
    STREAM,
    DONE
  } drain_state_t;

endpackage

// File: rtl/sd_pingpong_ram.sv
// Ping-pong sample buffer: two 256-word banks in one 512x16 simple dual-port RAM.
// The registered read port is the word presented to the sector writer; a pad
// request loads PAD_WORD instead of RAM contents (used past the end of a bank).
module sd_pingpong_ram import sd_sched_pkg::*; #(
  parameter logic [DATA_W-1:0] PAD_WORD = '0
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              we,
  input  logic [IDX_W:0]    waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W:0]    raddr,
  input  logic              rpad,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:2*SECTOR_WORDS-1];

  // Write port: storage only, no reset so the array maps onto block RAM.
  always_ff @(posedge sys_clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: output register holds its value between requests.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= rpad ? PAD_WORD : mem[raddr];
    end
  end

endmodule

// File: rtl/sd_sector_scheduler.sv
// Buffers a 16-bit sample stream into two 256-word banks and hands each full
// bank to the SPI sector writer as one single-block write at consecutive
// sector addresses. Fill side accepts/pads words; drain FSM runs the writer.
module sd_sector_scheduler import sd_sched_pkg::*; #(
  parameter logic [ADDR_W-1:0] START_SECTOR = 32'd0,
  parameter logic [DATA_W-1:0] PAD_WORD     = 16'h0000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              init_end,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  input  logic              wr_busy,
  input  logic              wr_req,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] sectors_written,
  output logic              overflow
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SECTOR_WORDS - 1);

  // fill side
  logic              run_reg;
  logic [1:0]        full_reg, full_next;
  logic              fill_bank_reg, fill_bank_next;
  logic [IDX_W-1:0]  fill_idx_reg, fill_idx_next;
  logic              pad_reg, pad_next;
  logic              overflow_reg, overflow_next;
  logic              accept;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic              bank_done;

  // drain side
  drain_state_t      state_reg, state_next;
  logic              drain_bank_reg, drain_bank_next;
  logic [IDX_W:0]    rd_idx_reg, rd_idx_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W-1:0] count_reg, count_next;
  logic              ram_re;
  logic              drain_release;

  // run_reg keeps in_ready low while reset is asserted and for the first cycle after.
  assign in_ready      = run_reg & init_end & ~full_reg[fill_bank_reg] & ~pad_reg;
  assign accept        = in_valid & in_ready;
  assign ram_we        = accept | pad_reg;
  assign ram_wdata     = pad_reg ? PAD_WORD : in_data;
  assign bank_done     = ram_we & (fill_idx_reg == LAST_IDX);
  assign drain_release = (state_reg == DONE);

  assign wr_addr         = addr_reg;
  assign sectors_written = count_reg;
  assign overflow        = overflow_reg;

  // Fill index / bank / pad control: a flush only starts padding if the bank
  // is still partial after this cycle's write.
  always_comb begin
    fill_idx_next  = fill_idx_reg;
    fill_bank_next = fill_bank_reg;
    pad_next       = pad_reg;
    if (ram_we) begin
      if (bank_done) begin
        fill_idx_next  = '0;
        fill_bank_next = ~fill_bank_reg;
        pad_next       = 1'b0;
      end else begin
        fill_idx_next = fill_idx_reg + IDX_W'(1);
      end
    end
    if (flush && !pad_reg && (fill_idx_next != '0)) begin
      pad_next = 1'b1;
    end
  end

  // Bank-full flags: fill and drain always address different banks, so both
  // updates may land on the same edge.
  always_comb begin
    full_next = full_reg;
    if (bank_done) begin
      full_next[fill_bank_reg] = 1'b1;
    end
    if (drain_release) begin
      full_next[drain_bank_reg] = 1'b0;
    end
  end

  // Sticky overflow: a word was offered after init while it could not be taken.
  always_comb begin
    overflow_next = overflow_reg | (run_reg & init_end & in_valid & ~in_ready);
  end

  // Drain FSM next-state and outputs.
  always_comb begin
    state_next      = state_reg;
    wr_en           = 1'b0;
    ram_re          = 1'b0;
    rd_idx_next     = rd_idx_reg;
    drain_bank_next = drain_bank_reg;
    addr_next       = addr_reg;
    count_next      = count_reg;
    case (state_reg)
      WAIT_INIT: begin
        if (init_end) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        if (!init_end) begin
          state_next = WAIT_INIT;
        end else if (full_reg[drain_bank_reg] && !wr_busy) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        wr_en       = 1'b1;
        rd_idx_next = '0;
        state_next  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (wr_busy) begin
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (wr_req) begin
          ram_re = 1'b1;
          // saturate at SECTOR_WORDS: extra requests read PAD_WORD, never the other bank
          if (!rd_idx_reg[IDX_W]) begin
            rd_idx_next = rd_idx_reg + (IDX_W+1)'(1);
          end
        end
        if (!wr_busy) begin
          state_next = DONE;
        end
      end
      DONE: begin
        drain_bank_next = ~drain_bank_reg;
        addr_next       = addr_reg + ADDR_W'(1);
        count_next      = count_reg + ADDR_W'(1);
        state_next      = IDLE;
      end
      default: begin
        state_next = WAIT_INIT;
      end
    endcase
  end

  // State registers for both sides.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      run_reg        <= 1'b0;
      full_reg       <= '0;
      fill_bank_reg  <= 1'b0;
      fill_idx_reg   <= '0;
      pad_reg        <= 1'b0;
      overflow_reg   <= 1'b0;
      state_reg      <= WAIT_INIT;
      drain_bank_reg <= 1'b0;
      rd_idx_reg     <= '0;
      addr_reg       <= START_SECTOR;
      count_reg      <= '0;
    end else begin
      run_reg        <= 1'b1;
      full_reg       <= full_next;
      fill_bank_reg  <= fill_bank_next;
      fill_idx_reg   <= fill_idx_next;
      pad_reg        <= pad_next;
      overflow_reg   <= overflow_next;
      state_reg      <= state_next;
      drain_bank_reg <= drain_bank_next;
      rd_idx_reg     <= rd_idx_next;
      addr_reg       <= addr_next;
      count_reg      <= count_next;
    end
  end

  sd_pingpong_ram #(
    .PAD_WORD (PAD_WORD)
  ) u_ram (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .we        (ram_we),
    .waddr     ({fill_bank_reg, fill_idx_reg}),
    .wdata     (ram_wdata),
    .re        (ram_re),
    .raddr     ({drain_bank_reg, rd_idx_reg[IDX_W-1:0]}),
    .rpad      (rd_idx_reg[IDX_W]),
    .rdata     (wr_data)
  );

endmodule

// File: tb/tb_sd_sector_scheduler.sv
// Bench for sd_sector_scheduler: a writer model captures every sector; the
// reference is the plain list of accepted words (plus flush padding), cut into
// 256-word sectors at consecutive addresses from START.
module tb_sd_sector_scheduler;

  localparam logic [31:0] START = 32'hFFFF_FFFE;
  localparam logic [15:0] PAD   = 16'h0000;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        init_end = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        wr_busy;
  logic        wr_req;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [15:0] wr_data;
  logic [31:0] sectors_written;
  logic        overflow;

  sd_sector_scheduler #(
    .START_SECTOR (START),
    .PAD_WORD     (PAD)
  ) dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .init_end        (init_end),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .flush           (flush),
    .wr_busy         (wr_busy),
    .wr_req          (wr_req),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .sectors_written (sectors_written),
    .overflow        (overflow)
  );

  always #10 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model and captures
  logic [15:0] model_q[$];
  logic [31:0] cap_addr_q[$];
  logic [15:0] cap_data_q[$];
  logic [15:0] cap_extra_q[$];
  logic [15:0] wbuf[$];
  logic [31:0] wa;
  bit          wab;
  int          en_count = 0;
  int          en_overlap = 0;
  int          addr_unstable = 0;
  int          cur_words = 0;
  int          n_acc = 0;
  int          first_rej = -1;
  int          stall_cycles = 0;
  int          n_req = 256;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Writer model: busy from the cycle after wr_en, n_req requests one every
  // 4 cycles, optional stall, then busy falls. Reset aborts the sector.
  initial begin
    wr_busy = 1'b0;
    wr_req  = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n && wr_en) begin
        wa = wr_addr;
        wab = 1'b0;
        wbuf.delete();
        en_count++;
        cur_words = 0;
        @(negedge sys_clk);
        wr_busy = 1'b1;
        for (int i = 0; i < n_req && !wab; i++) begin
          repeat (3) begin
            @(negedge sys_clk);
            if (!sys_rst_n) wab = 1'b1;
          end
          if (!wab) begin
            wr_req = 1'b1;
            @(negedge sys_clk);
            wr_req = 1'b0;
            if (!sys_rst_n) wab = 1'b1;
            else begin
              wbuf.push_back(wr_data);
              cur_words++;
              if (wr_addr !== wa) addr_unstable++;
            end
          end
        end
        for (int i = 0; i < stall_cycles && !wab; i++) begin
          @(negedge sys_clk);
          if (!sys_rst_n) wab = 1'b1;
        end
        wr_busy = 1'b0;
        if (!wab) begin
          cap_addr_q.push_back(wa);
          foreach (wbuf[j]) begin
            if (j < 256) cap_data_q.push_back(wbuf[j]);
            else cap_extra_q.push_back(wbuf[j]);
          end
          $display("sector addr=%h words=%0d", wa, wbuf.size());
        end
      end
    end
  end

  // A new write must never start while the writer is still busy.
  always @(negedge sys_clk) begin
    if (sys_rst_n && wr_en && wr_busy) en_overlap++;
  end

  initial begin
    repeat (95000) @(posedge sys_clk);
    $display("FAIL watchdog: cycle budget exhausted");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    repeat (3) @(negedge sys_clk);
    model_q.delete();
    cap_addr_q.delete();
    cap_data_q.delete();
    cap_extra_q.delete();
    en_count = 0;
    en_overlap = 0;
    addr_unstable = 0;
    cur_words = 0;
    n_acc = 0;
    first_rej = -1;
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
  endtask

  // Offer n words, each for one cycle only (not retried if refused).
  task automatic offer(input int n, input int gap_max, input bit ramp);
    int gap;
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      in_valid = 1'b1;
      in_data  = ramp ? 16'(i) : 16'($urandom);
      #1;
      if (in_ready) begin
        model_q.push_back(in_data);
        n_acc++;
      end else if (first_rej < 0) begin
        first_rej = i;
      end
      if (gap_max > 0) begin
        gap = int'($urandom_range(gap_max, 0));
        if (gap > 0) begin
          @(negedge sys_clk);
          in_valid = 1'b0;
          repeat (gap - 1) @(negedge sys_clk);
        end
      end
    end
    @(negedge sys_clk);
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge sys_clk);
    flush = 1'b1;
    if (model_q.size() % 256 != 0) begin
      while (model_q.size() % 256 != 0) model_q.push_back(PAD);
    end
    @(negedge sys_clk);
    flush = 1'b0;
    repeat (260) @(negedge sys_clk);
  endtask

  task automatic wait_sectors(input string tag, input int n, input int budget);
    int c = 0;
    while (cap_addr_q.size() < n && c < budget) begin
      @(negedge sys_clk);
      c++;
    end
    check({tag, "_wait"}, 32'(cap_addr_q.size() >= n), 32'd1);
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic compare_all(input string tag);
    int nsec = model_q.size() / 256;
    check({tag, "_nsec"}, 32'(cap_addr_q.size()), 32'(nsec));
    for (int k = 0; k < nsec && k < cap_addr_q.size(); k++) begin
      check({tag, "_addr"}, cap_addr_q[k], START + 32'(k));
      for (int w = 0; w < 256; w++) begin
        check({tag, "_data"}, 32'(cap_data_q[k*256+w]), 32'(model_q[k*256+w]));
      end
    end
    check({tag, "_count"}, sectors_written, 32'(nsec));
    check({tag, "_next_addr"}, wr_addr, START + 32'(nsec));
    check({tag, "_addr_stable"}, 32'(addr_unstable), 32'd0);
    check({tag, "_overlap"}, 32'(en_overlap), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    check({tag, "_wr_addr"}, wr_addr, START);
    check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    check({tag, "_sectors"}, sectors_written, 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    int c;
    int nr;
    // reset state, init_end already high
    init_end = 1'b1;
    repeat (2) @(negedge sys_clk);
    check_reset_outputs("rst");
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // T1: ramp 0..255, one extra request past the sector end
    do_reset();
    n_req = 257;
    stall_cycles = 0;
    offer(256, 0, 1'b1);
    wait_sectors("t1", 1, 3000);
    compare_all("t1");
    check("t1_wr_en_count", 32'(en_count), 32'd1);
    check("t1_extra_n", 32'(cap_extra_q.size()), 32'd1);
    if (cap_extra_q.size() > 0) check("t1_extra_pad", 32'(cap_extra_q[0]), 32'(PAD));
    n_req = 256;

    // T2: 512 words back-to-back, slow writer
    do_reset();
    stall_cycles = 20000;
    offer(512, 0, 1'b0);
    check("t2_accepted", 32'(n_acc), 32'd512);
    check("t2_no_reject", 32'(first_rej), 32'hFFFF_FFFF);
    wait_sectors("t2", 2, 50000);
    compare_all("t2");
    check("t2_wr_en_count", 32'(en_count), 32'd2);

    // T3: 600 words while the writer is stalled
    do_reset();
    stall_cycles = 3000;
    offer(600, 0, 1'b0);
    check("t3_accepted", 32'(n_acc), 32'd512);
    check("t3_first_reject", 32'(first_rej), 32'd512);
    check("t3_overflow", 32'(overflow), 32'd1);
    wait_sectors("t3", 2, 12000);
    compare_all("t3");
    stall_cycles = 0;

    // T4: 100 words + flush, then a full bank must still start at index 0
    do_reset();
    offer(100, 0, 1'b0);
    do_flush();
    check("t4_model_len", 32'(model_q.size()), 32'd256);
    wait_sectors("t4a", 1, 3000);
    offer(256, 0, 1'b0);
    wait_sectors("t4b", 2, 3000);
    compare_all("t4");

    // Randomized: bursts with gaps and random flushes
    do_reset();
    for (int r = 0; r < 3; r++) begin
      nr = int'($urandom_range(200, 1));
      offer(nr, 3, 1'b0);
      if ($urandom_range(1, 0) == 1) do_flush();
    end
    do_flush();
    wait_sectors("rnd", model_q.size() / 256, 12000);
    compare_all("rnd");

    // T5: card not initialised
    do_reset();
    init_end = 1'b0;
    offer(256, 0, 1'b0);
    repeat (20) @(negedge sys_clk);
    check("t5_accepted", 32'(n_acc), 32'd0);
    check("t5_wr_en_count", 32'(en_count), 32'd0);
    check("t5_overflow", 32'(overflow), 32'd0);
    init_end = 1'b1;

    // T6: reset during STREAM
    do_reset();
    offer(256, 0, 1'b0);
    c = 0;
    while (cur_words < 50 && c < 3000) begin
      @(negedge sys_clk);
      c++;
    end
    check("t6_mid_stream", 32'(cur_words >= 50), 32'd1);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    check_reset_outputs("t6_rst");
    do_reset();
    offer(256, 0, 1'b0);
    wait_sectors("t6", 1, 3000);
    compare_all("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
